// File: rtl/mm_pkg.sv
// Shared constants for the p = 2^255-19 arithmetic units (modular multiplier and inverse).
package mm_pkg;
  localparam int WIDTH = 255;
  localparam int CNT_W = $clog2(WIDTH);
  // 2^255 - 19 == 255'h7FFF...FFED
  localparam logic [WIDTH-1:0] PRIME = {WIDTH{1'b1}} - WIDTH'(18);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mm_state_e;
endpackage

// File: rtl/mod_dbl_add.sv
// One MSB-first multiply step: acc' = (2*acc + bit*a) mod p, with acc, a already < p.
module mod_dbl_add
  import mm_pkg::*;
(
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] s_o
);
  localparam logic [WIDTH:0] P_W = {1'b0, PRIME};

  logic [WIDTH:0] dbl, dbl_r, sum, sum_r;

  // Both operands are < p, so each stage stays below 2p and one subtract is exact.
  always_comb begin
    dbl   = {acc_i, 1'b0};
    dbl_r = (dbl >= P_W) ? dbl - P_W : dbl;
    sum   = bit_i ? dbl_r + {1'b0, a_i} : dbl_r;
    sum_r = (sum >= P_W) ? sum - P_W : sum;
  end

  assign s_o = sum_r[WIDTH-1:0];
endmodule

// File: rtl/mod_mul_verify.sv
// Bit-serial (a*b) mod (2^255-19), one multiplier bit per cycle, MSB first.
// MOD_MUL_VERIFY_IS_ONE_EN: builds the product==1 flag; otherwise mm_is_one is tied low.
module mod_mul_verify
  import mm_pkg::*;
(
  input  logic             mm_clk,
  input  logic             mm_reset_n,
  input  logic             mm_valid,
  input  logic [WIDTH-1:0] mm_a,
  input  logic [WIDTH-1:0] mm_b,
  output logic             mm_ready,
  output logic [WIDTH-1:0] mm_product,
  output logic             mm_is_one,
  output logic             mm_data_valid
);
  mm_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             dv_q, dv_d;
  logic [WIDTH-1:0] step;

  mod_dbl_add u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .bit_i (b_q[cnt_q]),
    .s_o   (step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mm_valid) begin
          // Any 255-bit value is < 2p, so one subtract fully reduces the multiplicand.
          a_d     = (mm_a >= PRIME) ? mm_a - PRIME : mm_a;
          b_d     = mm_b;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step;
        if (cnt_q == '0) begin
          prod_d  = step;
          dv_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mm_clk or negedge mm_reset_n) begin
    if (!mm_reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      dv_q    <= dv_d;
    end
  end

`ifdef MOD_MUL_VERIFY_IS_ONE_EN
  logic is_one_q;

  always_ff @(posedge mm_clk or negedge mm_reset_n) begin
    if (!mm_reset_n) is_one_q <= 1'b0;
    else if (state_q == RUN && cnt_q == '0) is_one_q <= (step == WIDTH'(1));
  end

  assign mm_is_one = is_one_q;
`else
  assign mm_is_one = 1'b0;
`endif

  assign mm_ready      = (state_q == IDLE);
  assign mm_product    = prod_q;
  assign mm_data_valid = dv_q;
endmodule

// File: doc/mod_mul_verify.md
# mod_mul_verify

Bit-serial modular multiplier over p = 2^255 − 19. It computes mm_a · mm_b mod p with one multiplier bit per cycle, MSB first. It sits downstream of the modular-inverse unit as its consumer and checker. Given an operand and the inverse returned for it, the block produces the product and flags whether it equals 1. It is also used as the general multiply step after inversion, for projective-to-affine conversion.

## Interface
- WIDTH, 255, operand/result width; the prime is fixed at 2^255 − 19.
- mm_clk  input  1  rising-edge clock.
- mm_reset_n  input  1  asynchronous, active-low reset.
- mm_valid  input  1  request strobe; sampled only while mm_ready = 1.
- mm_a  input  WIDTH  multiplicand; any value, reduced once on load.
- mm_b  input  WIDTH  multiplier; any value, never reduced.
- mm_ready  output  1  high while state = IDLE (decoded from state).
- mm_product  output  WIDTH  (mm_a · mm_b) mod p; held until the next result.
- mm_is_one  output  1  mm_product == 1 (see Configuration).
- mm_data_valid  output  1  one-cycle pulse when mm_product/mm_is_one update.

## Operation
- States:
  - IDLE (ready).
  - RUN (iterating).
- IDLE:
  - mm_data_valid <= 0.
  - On mm_valid: a_r <= (mm_a >= p) ? mm_a − p : mm_a. A single subtraction suffices because 2^255 − 1 < 2p.
  - b_r <= mm_b; acc <= 0; cnt <= WIDTH−1; go to RUN.
- RUN step, all in one cycle:
  - d = 2·acc (WIDTH+1 bits); d = (d >= p) ? d − p : d.
  - s = b_r[cnt] ? d + a_r : d (WIDTH+1 bits); s = (s >= p) ? s − p : s.
  - acc <= s[WIDTH−1:0].
  - Invariant: acc < p and a_r < p, so every sum is < 2p and one conditional subtract is exact.
- RUN exit, when cnt == 0:
  - mm_product <= s and mm_is_one <= (s == 1).
  - mm_data_valid <= 1; state <= IDLE.
  - Otherwise cnt <= cnt − 1.
- mm_valid while busy is ignored; no queueing, no error.
- mm_a/mm_b are sampled only on the accept edge; later changes have no effect.
- a = 0 or b = 0 yields 0 after the full WIDTH iterations; there is no early exit.
- Reset (mm_reset_n low, any time, including mid-RUN):
  - state = IDLE; acc, a_r, b_r, cnt = 0.
  - mm_product = 0, mm_is_one = 0, mm_data_valid = 0.
  - An in-flight request is discarded and produces no pulse.

## Timing
- Accept edge E0: the edge where mm_ready = 1 and mm_valid = 1.
- Edges E1..E_WIDTH perform the iterations for cnt = WIDTH−1..0.
- mm_data_valid is high for exactly the cycle after E_WIDTH (255 cycles after accept).
- mm_ready rises in the same cycle as mm_data_valid.
- The earliest next accept is E_WIDTH+1, so throughput is one operation per WIDTH+1 cycles.
- All outputs are registered except mm_ready, which is decoded from state.
- Critical path: two chained (WIDTH+1)-bit add/compare/subtract stages per cycle.

## Configuration
- MOD_MUL_VERIFY_IS_ONE_EN
  - Defined: the (s == 1) comparator and its register are compiled in, and mm_is_one behaves as above.
  - Undefined: mm_is_one is tied to constant 0 and no comparator is built.
  - The port exists in both builds, and mm_product/mm_data_valid behaviour is identical.

## Structure
- Shared package mm_pkg holds:
  - the PRIME constant (255'h7FFF…FFED);
  - the state encoding (IDLE, RUN);
  - the counter width, CNT_W = $clog2(WIDTH).
- The package is shared with the inverse unit.
- One sub-module, mod_dbl_add: combinational (acc, a_r, bit) → next acc, i.e. double-reduce then conditional add-reduce. The top level keeps the FSM, counter and registers.

## Test plan
- a=2, b=3 → mm_product=6, mm_is_one=0; data_valid pulses 255 cycles after accept, for one cycle.
- a=2, b=0x3FFF…FFF7 ((p+1)/2) → mm_product=1, mm_is_one=1.
- a=p−1, b=p−1 → mm_product=1, mm_is_one=1; a=p (unreduced), b=5 → mm_product=0.
- Second mm_valid with a=7, b=7 pulsed mid-RUN → ignored; only the first result pulses; a=7, b=7 accepted at E256 gives 49.
- mm_reset_n low at cycle 100 of RUN → all outputs 0 asynchronously, mm_ready=1, no pulse; a new request then completes correctly.
- Built without MOD_MUL_VERIFY_IS_ONE_EN, the (p+1)/2 case gives mm_product=1 and mm_is_one=0.
